// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and the MEM stage.
// Data requests win by default, but a capped grant streak lets a waiting fetch through.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_ready,
    output logic                  i_stall,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ready,
    output logic                  d_stall,
    output logic                  m_req,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_ack,
    output logic                  timeout_err
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

    state_e                state_q, state_d;
    logic [SW-1:0]         streak_q, streak_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  m_req_q, m_req_d;
    logic                  m_we_q, m_we_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  i_ready_q, i_ready_d;
    logic                  d_ready_q, d_ready_d;
    logic                  err_q, err_d;

    logic i_eff, d_eff, grant_i, grant_d;

    // A port's request is not re-arbitrated during its own ready cycle.
    assign i_eff   = i_req & ~i_ready_q;
    assign d_eff   = d_req & ~d_ready_q;
    assign grant_i = i_eff & (~d_eff | (streak_q == STREAK_MAX));
    assign grant_d = d_eff & ~grant_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            streak_q  <= '0;
            tmo_q     <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            tmo_q     <= tmo_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        tmo_d     = tmo_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d  = BUSY_I;
                    m_req_d  = 1'b1;
                    m_we_d   = 1'b0;
                    m_addr_d = i_addr;
                    streak_d = '0;
                    tmo_d    = '0;
                end else if (grant_d) begin
                    state_d   = BUSY_D;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    tmo_d     = '0;
                    if (!i_req) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 1'b1;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                // An ack in the final timeout cycle still counts as a normal completion.
                if (m_ack || (tmo_q == TMO_LAST)) begin
                    state_d = IDLE;
                    m_req_d = 1'b0;
                    if (state_q == BUSY_I) begin
                        i_ready_d = 1'b1;
                        i_rdata_d = m_ack ? m_rdata : '0;
                    end else begin
                        d_ready_d = 1'b1;
                        if (!m_we_q) begin
                            d_rdata_d = m_ack ? m_rdata : '0;
                        end
                    end
                    if (!m_ack) begin
                        err_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_req       = m_req_q;
        m_we        = m_we_q;
        m_addr      = m_addr_q;
        m_wdata     = m_wdata_q;
        i_rdata     = i_rdata_q;
        d_rdata     = d_rdata_q;
        i_ready     = i_ready_q;
        d_ready     = d_ready_q;
        timeout_err = err_q;
        i_stall     = i_req & ~i_ready_q;
        d_stall     = d_req & ~d_ready_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random and directed stimulus for mem_port_arbiter; a transaction-level model
// queues expected grants and ready pulses, and a monitor compares them against the DUT.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req, d_req, d_we, m_ack;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, m_rdata;
    logic [DW-1:0] i_rdata, d_rdata, m_wdata;
    logic [AW-1:0] m_addr;
    logic          i_ready, i_stall, d_ready, d_stall, m_req, m_we, timeout_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .timeout_err(timeout_err)
    );

    typedef struct {
        bit            isData;
        logic [DW-1:0] data;
    } ready_t;

    typedef struct {
        logic [AW-1:0] addr;
        bit            we;
        logic [DW-1:0] wdata;
    } grant_t;

    ready_t readyQ[$];
    grant_t grantQ[$];
    int     total = 0;
    int     bad = 0;

    // Reference model: which port owns the memory, how long it has waited,
    // and what each requester should see on completion.
    int            mdlOwner;
    bit            mdlWe;
    int            mdlWait;
    int            mdlStreak;
    bit            mdlIReady, mdlDReady, mdlErr;
    logic [DW-1:0] mdlIData, mdlDData;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Model update at each edge, from the inputs seen at that edge.
    always @(posedge clk or negedge rst_n) begin
        bit            iWants, dWants, wasI, wasD, done;
        logic [DW-1:0] value;
        grant_t        g;
        ready_t        r;
        if (!rst_n) begin
            mdlOwner  = 0;
            mdlWe     = 0;
            mdlWait   = 0;
            mdlStreak = 0;
            mdlIReady = 0;
            mdlDReady = 0;
            mdlErr    = 0;
            mdlIData  = '0;
            mdlDData  = '0;
            readyQ.delete();
            grantQ.delete();
        end else begin
            wasI = mdlIReady;
            wasD = mdlDReady;
            mdlIReady = 0;
            mdlDReady = 0;
            if (mdlOwner == 0) begin
                iWants = i_req && !wasI;
                dWants = d_req && !wasD;
                if (iWants && (!dWants || mdlStreak == SL)) begin
                    mdlOwner = 1;
                    mdlWe = 0;
                    mdlWait = 0;
                    mdlStreak = 0;
                    g.addr = i_addr; g.we = 0; g.wdata = '0;
                    grantQ.push_back(g);
                end else if (dWants) begin
                    mdlOwner = 2;
                    mdlWe = d_we;
                    mdlWait = 0;
                    mdlStreak = i_req ? ((mdlStreak < SL) ? mdlStreak + 1 : SL) : 0;
                    g.addr = d_addr; g.we = d_we; g.wdata = d_wdata;
                    grantQ.push_back(g);
                end
            end else begin
                done = 0;
                value = m_rdata;
                if (m_ack) begin
                    done = 1;
                end else begin
                    mdlWait++;
                    if (mdlWait == TO) begin
                        done = 1;
                        value = '0;
                        mdlErr = 1;
                    end
                end
                if (done) begin
                    if (mdlOwner == 1) begin
                        mdlIData = value;
                        mdlIReady = 1;
                        r.isData = 0; r.data = value;
                    end else begin
                        if (!mdlWe) mdlDData = value;
                        mdlDReady = 1;
                        r.isData = 1; r.data = mdlDData;
                    end
                    readyQ.push_back(r);
                    mdlOwner = 0;
                end
            end
        end
    end

    // Monitor: compares DUT outputs with the model between edges.
    bit     prevReq;
    grant_t curGrant;
    always @(negedge clk) begin
        ready_t e;
        if (!rst_n) begin
            prevReq = 0;
        end else begin
            checkOutput("i_stall", i_stall, i_req & ~mdlIReady);
            checkOutput("d_stall", d_stall, d_req & ~mdlDReady);
            checkOutput("timeout_err", timeout_err, mdlErr);
            checkOutput("m_req", m_req, mdlOwner != 0);
            if (m_req && !prevReq) begin
                if (grantQ.size() == 0) begin
                    checkOutput("grant_expected", 1'b0, 1'b1);
                end else begin
                    curGrant = grantQ.pop_front();
                    checkOutput("m_addr", m_addr, curGrant.addr);
                    checkOutput("m_we", m_we, curGrant.we);
                    if (curGrant.we) checkOutput("m_wdata", m_wdata, curGrant.wdata);
                end
            end else if (m_req) begin
                checkOutput("m_addr_hold", m_addr, curGrant.addr);
                checkOutput("m_we_hold", m_we, curGrant.we);
                if (curGrant.we) checkOutput("m_wdata_hold", m_wdata, curGrant.wdata);
            end
            if (i_ready || d_ready || readyQ.size() != 0) begin
                if (readyQ.size() == 0) begin
                    checkOutput("ready_unexpected", {i_ready, d_ready}, 2'b00);
                end else begin
                    e = readyQ.pop_front();
                    checkOutput("ready_port", {i_ready, d_ready}, e.isData ? 2'b01 : 2'b10);
                    if (e.isData) checkOutput("d_rdata", d_rdata, e.data);
                    else          checkOutput("i_rdata", i_rdata, e.data);
                end
            end
            prevReq = m_req;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Ack after lat busy cycles; returns in the ready cycle.
    task automatic ackAfter(input int lat, input logic [DW-1:0] data);
        for (int k = 1; k <= lat; k++) begin
            m_ack = (k == lat);
            m_rdata = data;
            cycle();
        end
        m_ack = 0;
    endtask

    // Requesters follow the hold-until-ready protocol; probabilities in percent.
    task automatic applyStimulus(input int iProb, input int dProb, input int ackProb);
        if (i_req) begin
            if (i_ready) begin
                if ($urandom_range(99) < iProb) i_addr = $urandom;
                else i_req = 0;
            end
        end else if ($urandom_range(99) < iProb) begin
            i_req = 1;
            i_addr = $urandom;
        end
        if (d_req) begin
            if (d_ready) begin
                if ($urandom_range(99) < dProb) begin
                    d_addr = $urandom; d_we = 1'($urandom_range(1)); d_wdata = $urandom;
                end else begin
                    d_req = 0;
                end
            end
        end else if ($urandom_range(99) < dProb) begin
            d_req = 1;
            d_addr = $urandom; d_we = 1'($urandom_range(1)); d_wdata = $urandom;
        end
        m_ack = ($urandom_range(99) < ackProb);
        m_rdata = $urandom;
    endtask

    task automatic drain();
        i_req = 0;
        d_req = 0;
        m_ack = 1;
        repeat (4) cycle();
        m_ack = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1;
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        m_ack = 0; m_rdata = '0;
        #1 rst_n = 0;
        #12;
        checkOutput("rst_m_req", m_req, 1'b0);
        checkOutput("rst_m_we", m_we, 1'b0);
        checkOutput("rst_m_addr", m_addr, 32'h0);
        checkOutput("rst_i_ready", i_ready, 1'b0);
        checkOutput("rst_d_ready", d_ready, 1'b0);
        checkOutput("rst_i_rdata", i_rdata, 32'h0);
        checkOutput("rst_d_rdata", d_rdata, 32'h0);
        checkOutput("rst_timeout_err", timeout_err, 1'b0);
        cycle();
        rst_n = 1;
        cycle();

        // Single instruction read with ack in the first busy cycle.
        i_req = 1; i_addr = 32'h0000_0040;
        cycle();
        checkOutput("t1_m_req", m_req, 1'b1);
        checkOutput("t1_m_addr", m_addr, 32'h40);
        ackAfter(1, 32'h2008_0005);
        checkOutput("t1_i_ready", i_ready, 1'b1);
        checkOutput("t1_i_rdata", i_rdata, 32'h2008_0005);
        checkOutput("t1_m_req_drop", m_req, 1'b0);
        i_req = 0;
        cycle();

        // Simultaneous requests: data first, fetch granted in the data ready cycle.
        i_req = 1; i_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h100;
        cycle();
        checkOutput("t2_d_first", m_addr, 32'h100);
        ackAfter(3, 32'h1111_2222);
        checkOutput("t2_d_ready", d_ready, 1'b1);
        checkOutput("t2_d_rdata", d_rdata, 32'h1111_2222);
        checkOutput("t2_i_stall", i_stall, 1'b1);
        d_req = 0;
        cycle();
        checkOutput("t2_i_next", m_addr, 32'h80);
        ackAfter(2, 32'h3333_4444);
        checkOutput("t2_i_rdata", i_rdata, 32'h3333_4444);
        i_req = 0;
        cycle();

        // Store: load data must be unaffected.
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hCAFE_F00D;
        cycle();
        checkOutput("t3_m_we", m_we, 1'b1);
        checkOutput("t3_m_wdata", m_wdata, 32'hCAFE_F00D);
        ackAfter(3, 32'hDEAD_BEEF);
        checkOutput("t3_d_ready", d_ready, 1'b1);
        checkOutput("t3_d_rdata_held", d_rdata, 32'h1111_2222);
        d_req = 0; d_we = 0;
        cycle();

        // Both requesters keep re-requesting.
        repeat (60) begin
            applyStimulus(100, 100, 50);
            cycle();
        end
        drain();

        // Memory never acknowledges a data read.
        d_req = 1; d_we = 0; d_addr = 32'h300; m_ack = 0;
        n = 0;
        while (!d_ready && n < 300) begin
            cycle();
            n++;
        end
        checkOutput("t5_abort_latency", n, 256);
        checkOutput("t5_d_rdata_zero", d_rdata, 32'h0);
        checkOutput("t5_err", timeout_err, 1'b1);
        d_req = 0;
        cycle();
        repeat (100) begin
            applyStimulus(40, 40, 50);
            cycle();
        end
        drain();
        checkOutput("t5_err_sticky", timeout_err, 1'b1);

        // Reset in the middle of an instruction fetch.
        i_req = 1; i_addr = 32'h500;
        cycle();
        checkOutput("t6_busy", m_req, 1'b1);
        #2 rst_n = 0;
        #1;
        checkOutput("t6_m_req_async", m_req, 1'b0);
        checkOutput("t6_i_ready_async", i_ready, 1'b0);
        checkOutput("t6_err_async", timeout_err, 1'b0);
        cycle();
        cycle();
        rst_n = 1;
        cycle();
        checkOutput("t6_regrant", m_req, 1'b1);
        checkOutput("t6_regrant_addr", m_addr, 32'h500);
        ackAfter(1, 32'h0BAD_CAFE);
        checkOutput("t6_i_rdata", i_rdata, 32'h0BAD_CAFE);
        i_req = 0;
        cycle();

        repeat (400) begin
            applyStimulus(30, 30, 40);
            cycle();
        end
        drain();
        checkOutput("end_grants_drained", grantQ.size(), 0);
        checkOutput("end_readies_drained", readyQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
